l1mtx_input_stage: RTL and testbench

// - Slave-side input stage of the L1 AHB bus matrix, directly upstream of the S1 address decoder.
// - Accepts the master's address phase, forwards it live when the decoder reports active_dec.
// - Otherwise parks it in a holding register, stalls the master and replays it until granted.
// - Returns the decoder's selected HREADYOUT/HRESP to the master for the data phase.

---
 rtl/l1mtx_input_stage.sv | 181 ++++++++++++++++++
 tb/tb_l1mtx_input_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/l1mtx_input_stage.sv
// l1mtx_input_stage
// Slave-side input stage of the L1 AHB bus matrix, sitting in front of the
// S1 address decoder. An address phase is forwarded live when the decoder
// reports the chosen output stage is serving this port (active_dec).
// Otherwise it is parked in a holding register, the master is stalled, and
// the parked transfer is replayed until the decoder grants it. The data-phase
// HREADYOUT/HRESP selected by the decoder is returned to the master.
module l1mtx_input_stage #(
  parameter int UW = 32
) (
  // Clock and reset
  input  logic          HCLK,
  input  logic          HRESET,

  // Master-side address phase
  input  logic          HSELS,
  input  logic [31:0]   HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic [UW-1:0] HAUSERS,
  input  logic          HREADYS,

  // Decoder feedback
  input  logic          active_dec,
  input  logic          readyout_dec,
  input  logic [1:0]    resp_dec,

  // Towards the decoder / default slave
  output logic          sel_dec,
  output logic [21:0]   decode_addr_dec,
  output logic [1:0]    trans_dec,

  // Towards the output stages
  output logic [31:0]   addr_in,
  output logic          write_in,
  output logic [2:0]    size_in,
  output logic [2:0]    burst_in,
  output logic [3:0]    prot_in,
  output logic [UW-1:0] auser_in,
  output logic          held_tran,

  // Data-phase response to the master
  output logic          HREADYOUTS,
  output logic [1:0]    HRESPS
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // LIVE forwards master inputs; HELD replays the holding register.
  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } pend_state_t;

  pend_state_t   pend_reg;
  pend_state_t   pend_next;
  logic          dphase_reg;
  logic          dphase_next;
  logic          load_en;

  // Holding register: only written on a load, so it needs no reset.
  logic [31:0]   addr_hold_reg;
  logic [1:0]    trans_hold_reg;
  logic          write_hold_reg;
  logic [2:0]    size_hold_reg;
  logic [2:0]    burst_hold_reg;
  logic [3:0]    prot_hold_reg;
  logic [UW-1:0] auser_hold_reg;

  // Only NONSEQ/SEQ to this port are real transfers; IDLE/BUSY never park.
  logic valid_tran;
  assign valid_tran = HSELS & HTRANSS[1];

  // State register: reset discards any parked transfer immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_reg   <= ST_LIVE;
      dphase_reg <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      dphase_reg <= dphase_next;
    end
  end

  // Next-state decision: park, pass through, release, or hold.
  always_comb begin
    pend_next   = pend_reg;
    dphase_next = dphase_reg;
    load_en     = 1'b0;
    case (pend_reg)
      ST_LIVE: begin
        // Decisions are only made when the previous data phase completes,
        // so a load can never overlap an unfinished data phase.
        if (HREADYS) begin
          if (valid_tran) begin
            if (active_dec) begin
              dphase_next = 1'b1;
            end else begin
              pend_next   = ST_HELD;
              dphase_next = 1'b0;
              load_en     = 1'b1;
            end
          end else begin
            dphase_next = 1'b0;
          end
        end
      end
      ST_HELD: begin
        // The output stage only grants when its own bus is ready, so the
        // replayed address phase completes on this edge.
        if (active_dec) begin
          pend_next   = ST_LIVE;
          dphase_next = 1'b1;
        end
      end
      default: begin
        pend_next   = ST_LIVE;
        dphase_next = 1'b0;
      end
    endcase
  end

  // Capture the full address phase when it has to be parked.
  always_ff @(posedge HCLK) begin
    if (load_en) begin
      addr_hold_reg  <= HADDRS;
      trans_hold_reg <= HTRANSS;
      write_hold_reg <= HWRITES;
      size_hold_reg  <= HSIZES;
      burst_hold_reg <= HBURSTS;
      prot_hold_reg  <= HPROTS;
      auser_hold_reg <= HAUSERS;
    end
  end

  // Address-phase output mux: live master inputs or the parked copy.
  always_comb begin
    sel_dec   = HSELS;
    trans_dec = HTRANSS;
    addr_in   = HADDRS;
    write_in  = HWRITES;
    size_in   = HSIZES;
    burst_in  = HBURSTS;
    prot_in   = HPROTS;
    auser_in  = HAUSERS;
    held_tran = 1'b0;
    if (pend_reg == ST_HELD) begin
      // A parked transfer is always a selected NONSEQ/SEQ.
      sel_dec   = 1'b1;
      trans_dec = trans_hold_reg;
      addr_in   = addr_hold_reg;
      write_in  = write_hold_reg;
      size_in   = size_hold_reg;
      burst_in  = burst_hold_reg;
      prot_in   = prot_hold_reg;
      auser_in  = auser_hold_reg;
      held_tran = 1'b1;
    end
  end

  // The decoder only needs the region bits of the address.
  assign decode_addr_dec = addr_in[31:10];

  // Data-phase response: stall while parked, route the decoder while a
  // data phase is outstanding, otherwise answer zero-wait OKAY.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    if (pend_reg == ST_HELD) begin
      HREADYOUTS = 1'b0;
      HRESPS     = RESP_OKAY;
    end else if (dphase_reg) begin
      HREADYOUTS = readyout_dec;
      HRESPS     = resp_dec;
    end
  end

endmodule

// File: tb/tb_l1mtx_input_stage.sv
// Directed testbench for l1mtx_input_stage.
module tb_l1mtx_input_stage;

  localparam int UW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSELS;
  logic [31:0]   HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic [UW-1:0] HAUSERS;
  logic          HREADYS;
  logic          active_dec;
  logic          readyout_dec;
  logic [1:0]    resp_dec;
  logic          sel_dec;
  logic [21:0]   decode_addr_dec;
  logic [1:0]    trans_dec;
  logic [31:0]   addr_in;
  logic          write_in;
  logic [2:0]    size_in;
  logic [2:0]    burst_in;
  logic [3:0]    prot_in;
  logic [UW-1:0] auser_in;
  logic          held_tran;
  logic          HREADYOUTS;
  logic [1:0]    HRESPS;

  int checks = 0;
  int errors = 0;

  l1mtx_input_stage #(.UW(UW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HAUSERS(HAUSERS),
    .HREADYS(HREADYS),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec),
    .addr_in(addr_in), .write_in(write_in), .size_in(size_in), .burst_in(burst_in),
    .prot_in(prot_in), .auser_in(auser_in), .held_tran(held_tran),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    HSELS = 1'b1; HADDRS = 32'h0000_0400; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HAUSERS = '0;
    HREADYS = 1'b1; active_dec = 1'b0; readyout_dec = 1'b0; resp_dec = 2'b00;

    // Reset state: zero-wait OKAY, nothing held, select follows master.
    #2;
    chk("rst_hreadyout", HREADYOUTS, 1);
    chk("rst_hresp", HRESPS, 0);
    chk("rst_held", held_tran, 0);
    chk("rst_sel1", sel_dec, 1);
    HSELS = 1'b0; #1;
    chk("rst_sel0", sel_dec, 0);
    next_cycle();
    HRESET = 1'b0;
    next_cycle();

    // LIVE with HREADYS=0 must not load even with a valid transfer.
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_0800;
    active_dec = 1'b0; HREADYS = 1'b0; #1;
    next_cycle();
    chk("nordy_held", held_tran, 0);
    // BUSY is never held.
    HTRANSS = 2'b01; HREADYS = 1'b1;
    next_cycle();
    chk("busy_held", held_tran, 0);
    chk("busy_hreadyout", HREADYOUTS, 1);

    // Pass-through NONSEQ 0x400 granted immediately.
    HTRANSS = 2'b10; HADDRS = 32'h0000_0400; active_dec = 1'b1; readyout_dec = 1'b1;
    #1;
    chk("pass_held", held_tran, 0);
    chk("pass_daddr", decode_addr_dec, 22'h000001);
    chk("pass_addr", addr_in, 32'h0000_0400);
    chk("pass_trans", trans_dec, 2'b10);
    next_cycle();
    HTRANSS = 2'b00;
    chk("pass_dp_hreadyout", HREADYOUTS, 1);
    chk("pass_dp_hresp", HRESPS, 0);
    readyout_dec = 1'b0; #1;
    chk("pass_dp_routed", HREADYOUTS, 0);
    readyout_dec = 1'b1;
    next_cycle();
    // IDLE accepted: decoder ready no longer routed.
    readyout_dec = 1'b0; #1;
    chk("idle_zero_wait", HREADYOUTS, 1);

    // Held NONSEQ write 0x1C00, not granted for 3 cycles.
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = 32'h0000_1C00;
    HSIZES = 3'd2; HBURSTS = 3'd1; HPROTS = 4'd3; HAUSERS = 32'hA5A5_0001;
    HREADYS = 1'b1; active_dec = 1'b0; #1;
    chk("load_live_held", held_tran, 0);
    chk("load_live_daddr", decode_addr_dec, 22'h000007);
    next_cycle();
    // Master changes its inputs while stalled; parked copy must persist.
    HADDRS = 32'h0000_2000; HWRITES = 1'b0; HTRANSS = 2'b11; HSELS = 1'b0;
    HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HAUSERS = 32'h0;
    HREADYS = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("held%0d_flag", c), held_tran, 1);
      chk($sformatf("held%0d_daddr", c), decode_addr_dec, 22'h000007);
      chk($sformatf("held%0d_addr", c), addr_in, 32'h0000_1C00);
      chk($sformatf("held%0d_hreadyout", c), HREADYOUTS, 0);
      chk($sformatf("held%0d_hresp", c), HRESPS, 0);
      chk($sformatf("held%0d_sel", c), sel_dec, 1);
      chk($sformatf("held%0d_trans", c), trans_dec, 2'b10);
      chk($sformatf("held%0d_ctrl", c),
          {write_in, size_in, burst_in, prot_in, auser_in},
          {1'b1, 3'd2, 3'd1, 4'd3, 32'hA5A5_0001});
      next_cycle();
    end
    // Grant: parked transfer is issued this cycle.
    active_dec = 1'b1; #1;
    chk("grant_held", held_tran, 1);
    chk("grant_addr", addr_in, 32'h0000_1C00);
    next_cycle();
    // Data phase: decoder response routed; master now shows IDLE.
    active_dec = 1'b0; HSELS = 1'b1; HTRANSS = 2'b00;
    readyout_dec = 1'b0; resp_dec = 2'b01; HREADYS = 1'b0; #1;
    chk("rel_held", held_tran, 0);
    chk("rel_addr_live", addr_in, 32'h0000_2000);
    chk("err1_hreadyout", HREADYOUTS, 0);
    chk("err1_hresp", HRESPS, 2'b01);
    next_cycle();
    readyout_dec = 1'b1; #1;
    chk("err2_hreadyout", HREADYOUTS, 1);
    chk("err2_hresp", HRESPS, 2'b01);
    HREADYS = 1'b1;
    next_cycle();
    readyout_dec = 1'b0; #1;
    chk("post_err_hreadyout", HREADYOUTS, 1);
    chk("post_err_hresp", HRESPS, 0);

    // Reset pulsed while a transfer is parked.
    HTRANSS = 2'b10; HADDRS = 32'h0000_3000; active_dec = 1'b0; HREADYS = 1'b1;
    next_cycle();
    chk("rst_mid_pre_held", held_tran, 1);
    HADDRS = 32'h0000_5400; resp_dec = 2'b00;
    HRESET = 1'b1; #1;
    chk("rst_mid_held", held_tran, 0);
    chk("rst_mid_hreadyout", HREADYOUTS, 1);
    chk("rst_mid_addr", addr_in, 32'h0000_5400);
    next_cycle();
    HRESET = 1'b0; active_dec = 1'b1; #1;
    chk("fresh_live", held_tran, 0);
    next_cycle();
    HTRANSS = 2'b00; active_dec = 1'b0; readyout_dec = 1'b0; #1;
    chk("fresh_held", held_tran, 0);
    chk("fresh_dp_routed", HREADYOUTS, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
